score_feeder: RTL and testbench

Sits directly upstream of the BCD score counter. Collects gameplay hit events, applies a combo multiplier, buffers the awarded points, and drains them into the counter's 4-bit `score_inc` input. Every increment it emits is digit-safe: 1..9 per pulse, followed by a mandatory run of zero cycles. Without that pacing the counter's one-cycle input register and carry normalisation would drop points.

---
 rtl/score_pkg.sv | 17 +
 rtl/combo_tracker.sv | 47 ++++
 rtl/score_feeder.sv | 102 ++++++++++
 tb/tb_score_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score feeder.
// Rev 1.0
`default_nettype none

package score_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      GAP  = 1'b1
   } feeder_state_t;

   localparam logic [3:0] MAX_DIGIT_INC = 4'd9;
   localparam int         AWARD_W       = 7;

endpackage

`default_nettype wire

// File: rtl/combo_tracker.sv
// combo_tracker: combo multiplier and its frame-tick expiry window.
// Rev 1.0
`default_nettype none

module combo_tracker
   import score_pkg::*;
#(
   parameter int COMBO_WINDOW = 60,
   parameter int MAX_MULT     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hit_accept,
   input  logic       frame_tick,
   input  logic       clear,
   output logic [2:0] multiplier
);

   localparam int WIN_W = (COMBO_WINDOW < 1) ? 1 : $clog2(COMBO_WINDOW + 1);

   logic [WIN_W-1:0] window;
   logic [2:0]       mult_q;

   // A hit in the same cycle as a frame tick reloads the window and skips the decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mult_q <= 3'd1;
         window <= '0;
      end else if (clear) begin
         mult_q <= 3'd1;
         window <= '0;
      end else if (hit_accept) begin
         if (mult_q < 3'(MAX_MULT))
            mult_q <= mult_q + 3'd1;
         window <= WIN_W'(COMBO_WINDOW);
      end else if (frame_tick && (window != '0)) begin
         window <= window - WIN_W'(1);
         if (window == WIN_W'(1))
            mult_q <= 3'd1;
      end
   end

   assign multiplier = mult_q;

endmodule

`default_nettype wire

// File: rtl/score_feeder.sv
// score_feeder: awards combo-scaled hit points and drains them as digit-safe paced increments.
// Rev 1.0
`default_nettype none

module score_feeder
   import score_pkg::*;
#(
   parameter int PEND_W       = 16,
   parameter int GAP          = 3,
   parameter int COMBO_WINDOW = 60,
   parameter int MAX_MULT     = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              hit_valid,
   input  logic [3:0]        hit_points,
   input  logic              frame_tick,
   input  logic              clear,
   output logic [3:0]        score_inc,
   output logic [PEND_W-1:0] pending,
   output logic [2:0]        multiplier,
   output logic              busy
);

   localparam int GW    = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam int SUM_W = ((PEND_W > AWARD_W) ? PEND_W : AWARD_W) + 1;
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   feeder_state_t      state, state_next;
   logic [GW-1:0]      gap_cnt, gap_next;
   logic [3:0]         emit;
   logic               hit_accept;
   logic [AWARD_W-1:0] award;
   logic [SUM_W-1:0]   sum;
   logic [PEND_W-1:0]  pending_next;

   assign hit_accept = hit_valid && (hit_points != 4'd0) && !clear;
   assign award      = hit_accept ? (AWARD_W'(hit_points) * AWARD_W'(multiplier)) : '0;

   combo_tracker #(
      .COMBO_WINDOW (COMBO_WINDOW),
      .MAX_MULT     (MAX_MULT)
   ) u_combo (
      .clk        (Clk),
      .rst_n      (Reset),
      .hit_accept (hit_accept),
      .frame_tick (frame_tick),
      .clear      (clear),
      .multiplier (multiplier)
   );

   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      emit       = 4'd0;
      unique case (state)
         score_pkg::IDLE: begin
            if (pending != '0) begin
               emit       = (pending > PEND_W'(MAX_DIGIT_INC)) ? MAX_DIGIT_INC : pending[3:0];
               state_next = score_pkg::GAP;
               gap_next   = GW'(GAP);
            end
         end
         score_pkg::GAP: begin
            gap_next = gap_cnt - GW'(1);
            if (gap_cnt <= GW'(1))
               state_next = score_pkg::IDLE;
         end
         default: state_next = score_pkg::IDLE;
      endcase
   end

   // Emit never exceeds pending, so the subtraction cannot wrap before saturation.
   always_comb begin
      sum          = SUM_W'(pending) - SUM_W'(emit) + SUM_W'(award);
      pending_next = (sum > SUM_W'(PEND_MAX)) ? PEND_MAX : sum[PEND_W-1:0];
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= score_pkg::IDLE;
         gap_cnt   <= '0;
         score_inc <= 4'd0;
         pending   <= '0;
      end else if (clear) begin
         state     <= score_pkg::IDLE;
         gap_cnt   <= '0;
         score_inc <= 4'd0;
         pending   <= '0;
      end else begin
         state     <= state_next;
         gap_cnt   <= gap_next;
         score_inc <= emit;
         pending   <= pending_next;
      end
   end

   assign busy = (pending != '0) || (state != score_pkg::IDLE);

endmodule

`default_nettype wire

// File: tb/tb_score_feeder.sv
// tb_score_feeder: directed self-checking bench for score_feeder.
// Rev 1.0
`default_nettype none

module tb_score_feeder;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        hit_valid = 1'b0;
   logic [3:0]  hit_points = 4'd0;
   logic        frame_tick = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  score_inc;
   logic [15:0] pending;
   logic [2:0]  multiplier;
   logic        busy;

   logic        s_hit_valid = 1'b0;
   logic [3:0]  s_hit_points = 4'd0;
   logic        s_frame_tick = 1'b0;
   logic        s_clear = 1'b0;
   logic [3:0]  s_score_inc;
   logic [5:0]  s_pending;
   logic [2:0]  s_multiplier;
   logic        s_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   score_feeder dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .hit_valid  (hit_valid),
      .hit_points (hit_points),
      .frame_tick (frame_tick),
      .clear      (clear),
      .score_inc  (score_inc),
      .pending    (pending),
      .multiplier (multiplier),
      .busy       (busy)
   );

   score_feeder #(.PEND_W(6)) dut_sat (
      .Clk        (Clk),
      .Reset      (Reset),
      .hit_valid  (s_hit_valid),
      .hit_points (s_hit_points),
      .frame_tick (s_frame_tick),
      .clear      (s_clear),
      .score_inc  (s_score_inc),
      .pending    (s_pending),
      .multiplier (s_multiplier),
      .busy       (s_busy)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (score_inc !== 4'd0) begin n_fail++; $display("FAIL reset_score_inc: got %0d expected 0", score_inc); end
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending); end
      n_checks++; if (multiplier !== 3'd1) begin n_fail++; $display("FAIL reset_multiplier: got %0d expected 1", multiplier); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy); end
      Reset = 1'b1;
      tick();
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL reset_release_pending: got %0d expected 0", pending); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %0d expected 0", busy); end
   endtask

   task automatic test_single_hit();
      do_clear();
      hit_valid = 1'b1; hit_points = 4'd7;
      tick();
      hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (pending !== 16'd7) begin n_fail++; $display("FAIL single_pending: got %0d expected 7", pending); end
      n_checks++; if (multiplier !== 3'd2) begin n_fail++; $display("FAIL single_multiplier: got %0d expected 2", multiplier); end
      n_checks++; if (score_inc !== 4'd0) begin n_fail++; $display("FAIL single_latency: got %0d expected 0", score_inc); end
      tick();
      n_checks++; if (score_inc !== 4'd7) begin n_fail++; $display("FAIL single_pulse: got %0d expected 7", score_inc); end
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL single_drained: got %0d expected 0", pending); end
      tick();
      n_checks++; if (score_inc !== 4'd0) begin n_fail++; $display("FAIL single_pulse_end: got %0d expected 0", score_inc); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %0d expected 1", busy); end
      tick();
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %0d expected 0", busy); end
   endtask

   task automatic test_combo_burst();
      int sum = 0;
      int pulses = 0;
      int bad_size = 0;
      int bad_gap = 0;
      int run = -1;
      int done = 0;
      logic [15:0] p_e3 = '0;
      logic [2:0]  m_e1 = '0, m_e2 = '0, m_e3 = '0;
      do_clear();
      hit_valid = 1'b1; hit_points = 4'd15;
      for (int c = 0; c < 200 && done == 0; c++) begin
         tick();
         if (c == 0) m_e1 = multiplier;
         if (c == 1) m_e2 = multiplier;
         if (c == 2) begin
            m_e3 = multiplier; p_e3 = pending;
            hit_valid = 1'b0; hit_points = 4'd0;
         end
         if (score_inc != 4'd0) begin
            pulses++;
            sum += int'(score_inc);
            if (score_inc != 4'd9) bad_size++;
            if (run >= 0 && run != 3) bad_gap++;
            run = 0;
         end else if (run >= 0) begin
            run++;
         end
         if (c > 2 && !busy) done = 1;
      end
      n_checks++; if (m_e1 !== 3'd2) begin n_fail++; $display("FAIL burst_mult_1: got %0d expected 2", m_e1); end
      n_checks++; if (m_e2 !== 3'd3) begin n_fail++; $display("FAIL burst_mult_2: got %0d expected 3", m_e2); end
      n_checks++; if (m_e3 !== 3'd4) begin n_fail++; $display("FAIL burst_mult_3: got %0d expected 4", m_e3); end
      n_checks++; if (p_e3 !== 16'd81) begin n_fail++; $display("FAIL burst_pending: got %0d expected 81", p_e3); end
      n_checks++; if (done != 1) begin n_fail++; $display("FAIL burst_timeout: got %0d expected 1", done); end
      n_checks++; if (sum != 90) begin n_fail++; $display("FAIL burst_sum: got %0d expected 90", sum); end
      n_checks++; if (pulses != 10) begin n_fail++; $display("FAIL burst_pulses: got %0d expected 10", pulses); end
      n_checks++; if (bad_size != 0) begin n_fail++; $display("FAIL burst_pulse_size: got %0d bad pulses expected 0", bad_size); end
      n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL burst_gap: got %0d bad gaps expected 0", bad_gap); end
      n_checks++; if (multiplier !== 3'd4) begin n_fail++; $display("FAIL burst_mult_final: got %0d expected 4", multiplier); end
   endtask

   task automatic test_combo_expiry();
      do_clear();
      hit_valid = 1'b1; hit_points = 4'd3;
      tick();
      hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (multiplier !== 3'd2) begin n_fail++; $display("FAIL expiry_start: got %0d expected 2", multiplier); end
      frame_tick = 1'b1;
      repeat (59) tick();
      n_checks++; if (multiplier !== 3'd2) begin n_fail++; $display("FAIL expiry_tick59: got %0d expected 2", multiplier); end
      tick();
      frame_tick = 1'b0;
      n_checks++; if (multiplier !== 3'd1) begin n_fail++; $display("FAIL expiry_tick60: got %0d expected 1", multiplier); end
      hit_valid = 1'b1; hit_points = 4'd5;
      tick();
      hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (pending !== 16'd5) begin n_fail++; $display("FAIL expiry_award: got %0d expected 5", pending); end
      n_checks++; if (multiplier !== 3'd2) begin n_fail++; $display("FAIL expiry_rehit_mult: got %0d expected 2", multiplier); end
      frame_tick = 1'b1;
      repeat (59) tick();
      hit_valid = 1'b1; hit_points = 4'd2;
      tick();
      hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (multiplier !== 3'd3) begin n_fail++; $display("FAIL expiry_hit_wins: got %0d expected 3", multiplier); end
      tick();
      frame_tick = 1'b0;
      n_checks++; if (multiplier !== 3'd3) begin n_fail++; $display("FAIL expiry_window_reloaded: got %0d expected 3", multiplier); end
   endtask

   task automatic test_zero_points();
      do_clear();
      hit_valid = 1'b1; hit_points = 4'd0;
      tick();
      hit_valid = 1'b0;
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL zero_hit_pending: got %0d expected 0", pending); end
      n_checks++; if (multiplier !== 3'd1) begin n_fail++; $display("FAIL zero_hit_mult: got %0d expected 1", multiplier); end
   endtask

   task automatic test_clear();
      do_clear();
      hit_valid = 1'b1; hit_points = 4'd13;
      tick();
      hit_points = 4'd14;
      tick();
      hit_points = 4'd6;
      tick();
      hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (pending !== 16'd50) begin n_fail++; $display("FAIL clear_setup: got %0d expected 50", pending); end
      clear = 1'b1; hit_valid = 1'b1; hit_points = 4'd9;
      tick();
      clear = 1'b0; hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL clear_pending: got %0d expected 0", pending); end
      n_checks++; if (score_inc !== 4'd0) begin n_fail++; $display("FAIL clear_score_inc: got %0d expected 0", score_inc); end
      n_checks++; if (multiplier !== 3'd1) begin n_fail++; $display("FAIL clear_multiplier: got %0d expected 1", multiplier); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %0d expected 0", busy); end
      tick();
      n_checks++; if (score_inc !== 4'd0) begin n_fail++; $display("FAIL clear_abandoned: got %0d expected 0", score_inc); end
   endtask

   task automatic test_reset_mid_drain();
      int found = 0;
      do_clear();
      hit_valid = 1'b1; hit_points = 4'd13;
      tick();
      hit_points = 4'd12;
      tick();
      hit_points = 4'd4;
      tick();
      hit_valid = 1'b0; hit_points = 4'd0;
      n_checks++; if (pending !== 16'd40) begin n_fail++; $display("FAIL rst_setup: got %0d expected 40", pending); end
      for (int c = 0; c < 12 && found == 0; c++) begin
         tick();
         if (score_inc != 4'd0) found = 1;
      end
      n_checks++; if (found != 1) begin n_fail++; $display("FAIL rst_pulse_timeout: got %0d expected 1", found); end
      #2 Reset = 1'b0;
      #1;
      n_checks++; if (score_inc !== 4'd0) begin n_fail++; $display("FAIL rst_async_score_inc: got %0d expected 0", score_inc); end
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL rst_async_pending: got %0d expected 0", pending); end
      #1 Reset = 1'b1;
      tick();
      n_checks++; if (pending !== 16'd0) begin n_fail++; $display("FAIL rst_release_pending: got %0d expected 0", pending); end
      n_checks++; if (multiplier !== 3'd1) begin n_fail++; $display("FAIL rst_release_mult: got %0d expected 1", multiplier); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %0d expected 0", busy); end
   endtask

   task automatic test_saturation();
      int sum = 0;
      int done = 0;
      s_clear = 1'b1;
      tick();
      s_clear = 1'b0;
      s_hit_valid = 1'b1; s_hit_points = 4'd15;
      tick();
      n_checks++; if (s_pending !== 6'd15) begin n_fail++; $display("FAIL sat_p1: got %0d expected 15", s_pending); end
      tick();
      n_checks++; if (s_pending !== 6'd36) begin n_fail++; $display("FAIL sat_p2: got %0d expected 36", s_pending); end
      tick();
      n_checks++; if (s_pending !== 6'd63) begin n_fail++; $display("FAIL sat_p3: got %0d expected 63", s_pending); end
      tick();
      s_hit_valid = 1'b0; s_hit_points = 4'd0;
      n_checks++; if (s_pending !== 6'd63) begin n_fail++; $display("FAIL sat_hold: got %0d expected 63", s_pending); end
      n_checks++; if (s_multiplier !== 3'd4) begin n_fail++; $display("FAIL sat_mult: got %0d expected 4", s_multiplier); end
      for (int c = 0; c < 200 && done == 0; c++) begin
         tick();
         sum += int'(s_score_inc);
         if (!s_busy) done = 1;
      end
      n_checks++; if (done != 1) begin n_fail++; $display("FAIL sat_timeout: got %0d expected 1", done); end
      n_checks++; if (sum != 63) begin n_fail++; $display("FAIL sat_drained: got %0d expected 63", sum); end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_combo_burst();
      test_combo_expiry();
      test_zero_points();
      test_clear();
      test_reset_mid_drain();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
